// File: rtl/pipe_stage_buf.sv
// Elastic execute-to-writeback stage: DEPTH-entry ready/valid circular buffer
// carrying {payload, halt}, with synchronous flush and halt-triggered intake stop.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic [CNT_W-1:0]  count,
  output logic              halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] memData [DEPTH];
  logic              memHalt [DEPTH];

  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] occCnt;
  logic             haltLat;
  logic             pushEn;
  logic             popEn;

  // Wrap by explicit compare so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: ready depends only on registered occupancy and halt state.
  always_comb begin
    in_ready  = (occCnt < FULL_CNT) && !haltLat;
    out_valid = (occCnt != '0);
    pushEn    = in_valid && in_ready && !flush;
    popEn     = out_valid && out_ready && !flush;
  end

  // Control state: pointers, occupancy and halt latch; flush outranks everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      occCnt  <= '0;
      haltLat <= 1'b0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      occCnt  <= '0;
      haltLat <= 1'b0;
    end else begin
      if (pushEn) begin
        tailPtr <= ptrInc(tailPtr);
        if (in_halt) begin
          haltLat <= 1'b1;
        end
      end
      if (popEn) begin
        headPtr <= ptrInc(headPtr);
      end
      case ({pushEn, popEn})
        2'b10:   occCnt <= occCnt + CNT_W'(1);
        2'b01:   occCnt <= occCnt - CNT_W'(1);
        default: occCnt <= occCnt;
      endcase
    end
  end

  // Payload storage is never reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      memData[tailPtr] <= in_data;
      memHalt[tailPtr] <= in_halt;
    end
  end

  // Head entry straight from storage; halt tag masked so reset leaves it low.
  always_comb begin
    out_data = memData[headPtr];
    out_halt = out_valid && memHalt[headPtr];
    count    = occCnt;
    halted   = haltLat;
  end

  occNeverOver: assert property (@(posedge clk) disable iff (!rst_n)
    occCnt <= FULL_CNT);

  noPushPopWhenFull: assert property (@(posedge clk) disable iff (!rst_n)
    !(pushEn && popEn && (occCnt == FULL_CNT)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a DEPTH=2 and a DEPTH=3 buffer with identical stimulus and scores
// both against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic [DW-1:0] inData = '0;
  logic          inHalt = 1'b0;
  logic          outReady = 1'b0;

  logic [1:0]    inReady;
  logic [1:0]    outValid;
  logic [1:0]    outHalt;
  logic [1:0]    haltedQ;
  logic [DW-1:0] outData [2];
  logic [1:0]    cnt [2];

  int checks = 0;
  int errors = 0;

  // Reference model: queue of buffered {halt, data}, occupancy and halt flag.
  logic [DW:0] sbQ [2][$];
  int          mCnt [2];
  logic        mHalt [2];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady[0]), .in_data(inData), .in_halt(inHalt),
    .out_valid(outValid[0]), .out_ready(outReady), .out_data(outData[0]),
    .out_halt(outHalt[0]), .count(cnt[0]), .halted(haltedQ[0])
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady[1]), .in_data(inData), .in_halt(inHalt),
    .out_valid(outValid[1]), .out_ready(outReady), .out_data(outData[1]),
    .out_halt(outHalt[1]), .count(cnt[1]), .halted(haltedQ[1])
  );

  function automatic int depthOf(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      sbQ[k].delete();
      mCnt[k]  = 0;
      mHalt[k] = 1'b0;
    end
  endtask

  // One clock of stimulus; the model absorbs it after the monitor has sampled.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic h,
                      input logic rdy, input logic fl);
    logic push;
    logic pop;
    @(posedge clk);
    #1;
    inValid  = v;
    inData   = d;
    inHalt   = h;
    outReady = rdy;
    flush    = fl;
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        sbQ[k].delete();
        mCnt[k]  = 0;
        mHalt[k] = 1'b0;
      end else begin
        push = v && !mHalt[k] && (mCnt[k] < depthOf(k));
        pop  = (mCnt[k] != 0) && rdy;
        if (push) begin
          sbQ[k].push_back({h, d});
          if (h) mHalt[k] = 1'b1;
        end
        mCnt[k] = mCnt[k] + (push ? 1 : 0) - (pop ? 1 : 0);
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  // Monitor: compares visible state every cycle, pops on each DUT handshake.
  always @(negedge clk) begin
    logic [DW:0] exp;
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", k, 32'(outValid[k]), 32'(mCnt[k] != 0));
      chk("in_ready", k, 32'(inReady[k]), 32'(!mHalt[k] && (mCnt[k] < depthOf(k))));
      chk("count", k, 32'(cnt[k]), 32'(mCnt[k]));
      chk("halted", k, 32'(haltedQ[k]), 32'(mHalt[k]));
      if (outValid[k]) begin
        if (sbQ[k].size() == 0) begin
          chk("sb_underflow", k, 32'(outData[k]), 32'hFFFF_FFFF);
        end else begin
          exp = sbQ[k][0];
          chk("out_data", k, 32'(outData[k]), 32'(exp[DW-1:0]));
          chk("out_halt", k, 32'(outHalt[k]), 32'(exp[DW]));
          if (outReady && !flush && rst_n) void'(sbQ[k].pop_front());
        end
      end
    end
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 32'(outValid[k]), 32'd0);
      chk("rst_out_halt", k, 32'(outHalt[k]), 32'd0);
      chk("rst_in_ready", k, 32'(inReady[k]), 32'd1);
      chk("rst_count", k, 32'(cnt[k]), 32'd0);
      chk("rst_halted", k, 32'(haltedQ[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Fill then drain.
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("fill_count", 0, 32'(cnt[0]), 32'd2);
    chk("fill_in_ready", 0, 32'(inReady[0]), 32'd0);
    chk("fill_head", 0, 32'(outData[0]), 32'hA1);
    chk("fill_in_ready", 1, 32'(inReady[1]), 32'd1);
    repeat (3) idle(1'b1);
    chk("drain_count", 0, 32'(cnt[0]), 32'd0);

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Back-pressure with wrap: out_ready toggles.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, (i % 2) == 0, 1'b0);
    repeat (4) idle(1'b1);

    // Flush while push and pop are both requested.
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("flush_out_valid", k, 32'(outValid[k]), 32'd0);
      chk("flush_in_ready", k, 32'(inReady[k]), 32'd1);
    end

    // Halt latching, drain, then flush clears it.
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("halt_halted", k, 32'(haltedQ[k]), 32'd1);
      chk("halt_in_ready", k, 32'(inReady[k]), 32'd0);
    end
    repeat (3) idle(1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("unhalt_halted", k, 32'(haltedQ[k]), 32'd0);
      chk("unhalt_in_ready", k, 32'(inReady[k]), 32'd1);
    end

    // Asynchronous reset between edges with two entries buffered.
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b0;
    flush    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_out_valid", k, 32'(outValid[k]), 32'd0);
      chk("arst_count", k, 32'(cnt[k]), 32'd0);
      chk("arst_in_ready", k, 32'(inReady[k]), 32'd1);
    end
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h90, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h91, 1'b0, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3, 0) != 0), DW'($urandom), ($urandom_range(11, 0) == 0),
           ($urandom_range(2, 0) != 0), ($urandom_range(15, 0) == 0));
    end
    repeat (5) idle(1'b1);
    for (int k = 0; k < 2; k++) chk("sb_empty", k, 32'(sbQ[k].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
